// File: rtl/debounce_multi.sv
// debounce_multi: N-channel push-button conditioner.
// Each channel is synchronised through two flops and then debounced by its own
// four-state FSM. The FSM drives a clean level and one-cycle press, release and
// long-press pulses. A single counter per channel is reused for the debounce
// window and for long-press timing.
module debounce_multi #(
  parameter int CHANNELS        = 5,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int LONG_CYCLES     = 50000000,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] btn_level,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic [CHANNELS-1:0] btn_long
);

  localparam int CNT_W = $clog2(LONG_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_SAT  = CNT_W'(LONG_CYCLES);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_e;

  state_e              state_q [CHANNELS];
  state_e              state_d [CHANNELS];
  logic [CNT_W-1:0]    cnt_q   [CHANNELS];
  logic [CNT_W-1:0]    cnt_d   [CHANNELS];

  logic [CHANNELS-1:0] sync1_q, sync2_q;
  logic [CHANNELS-1:0] level_q, level_d;
  logic [CHANNELS-1:0] press_q, press_d;
  logic [CHANNELS-1:0] release_q, release_d;
  logic [CHANNELS-1:0] long_q, long_d;

  // Normalise polarity so that 1 means pressed, then pass the raw pins through a two-flop synchroniser.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= btn_in ^ {CHANNELS{ACTIVE_LOW}};
      sync2_q <= sync1_q;
    end
  end

  // Per-channel FSM state, shared counter and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= RELEASED;
        cnt_q[c]   <= '0;
      end
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
    end else begin
      for (int c = 0; c < CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
      end
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  // Next-state logic. Pulses default to 0, so each pulse lasts exactly one cycle.
  always_comb begin
    level_d   = level_q;
    press_d   = '0;
    release_d = '0;
    long_d    = '0;
    for (int c = 0; c < CHANNELS; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      case (state_q[c])
        RELEASED: begin
          if (sync2_q[c]) begin
            state_d[c] = PRESS_WAIT;
            cnt_d[c]   = CNT_ONE;
          end else begin
            cnt_d[c] = '0;
          end
        end
        PRESS_WAIT: begin
          if (!sync2_q[c]) begin
            state_d[c] = RELEASED;
            cnt_d[c]   = '0;
          end else if (cnt_q[c] == DEB_LAST) begin
            state_d[c] = PRESSED;
            level_d[c] = 1'b1;
            press_d[c] = 1'b1;
            cnt_d[c]   = '0;
          end else begin
            cnt_d[c] = cnt_q[c] + CNT_ONE;
          end
        end
        PRESSED: begin
          if (!sync2_q[c]) begin
            state_d[c] = RELEASE_WAIT;
            cnt_d[c]   = CNT_ONE;
          end else if (cnt_q[c] == LONG_LAST) begin
            long_d[c] = 1'b1;
            cnt_d[c]  = LONG_SAT;
          end else if (cnt_q[c] != LONG_SAT) begin
            cnt_d[c] = cnt_q[c] + CNT_ONE;
          end
        end
        RELEASE_WAIT: begin
          if (sync2_q[c]) begin
            state_d[c] = PRESSED;
            cnt_d[c]   = '0;
          end else if (cnt_q[c] == DEB_LAST) begin
            state_d[c]   = RELEASED;
            level_d[c]   = 1'b0;
            release_d[c] = 1'b1;
            cnt_d[c]     = '0;
          end else begin
            cnt_d[c] = cnt_q[c] + CNT_ONE;
          end
        end
        default: begin
          state_d[c] = RELEASED;
          cnt_d[c]   = '0;
        end
      endcase
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;
  assign btn_long    = long_q;

endmodule

// File: doc/debounce_multi.md
# debounce_multi

Parametrised multi-channel push-button conditioner for the board's button bank. Each channel gets a two-flop synchroniser, an independent debounce FSM and an edge/long-press event generator. It produces a clean level plus one-cycle press, release and long-press pulses for the game-logic FSMs. It is the N-channel successor of the single-button debouncer, with configurable polarity and long-press detection added.

## Interface
- CHANNELS, 5, number of independent button channels
- DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a new level (5 ms at 50 MHz); must be ≥2
- LONG_CYCLES, 50000000, cycles a debounced press must persist before btn_long fires (1 s at 50 MHz); must exceed DEBOUNCE_CYCLES
- ACTIVE_LOW, 0, 1 = raw pin reads 0 when pressed; inverted at input so all outputs are active-high

- clk  input  1  system clock; all logic on rising edge
- reset  input  1  synchronous, active-high; clears all state on the next rising edge
- btn_in  input  CHANNELS  raw asynchronous button pins
- btn_level  output  CHANNELS  debounced level, 1 = pressed
- btn_press  output  CHANNELS  one-cycle pulse on accepted press
- btn_release  output  CHANNELS  one-cycle pulse on accepted release
- btn_long  output  CHANNELS  one-cycle pulse, once per press, when press reaches LONG_CYCLES

## Operation
- Input: btn_in XOR ACTIVE_LOW feeds a 2-flop synchroniser per channel (sync1, sync2); sync2 is the sampled value s.
- Per-channel FSM states: RELEASED, PRESS_WAIT, PRESSED, RELEASE_WAIT. Debounce counter width = clog2(LONG_CYCLES+1), shared per channel by the debounce and long-press phases.
- RELEASED: s=1 -> PRESS_WAIT, cnt=1; else hold, cnt=0.
- PRESS_WAIT: s=0 -> RELEASED, cnt=0 (glitch rejected, no output); s=1 and cnt=DEBOUNCE_CYCLES-1 -> PRESSED, btn_level<=1, btn_press pulse, cnt=0; else cnt+1.
- PRESSED: s=0 -> RELEASE_WAIT, cnt=1 (long-press count abandoned); s=1 -> cnt saturating increment; when cnt reaches LONG_CYCLES-1 -> btn_long pulse, cnt saturates at LONG_CYCLES, no further long pulses this press.
- RELEASE_WAIT: s=1 -> PRESSED, cnt restarts at 0 for long-press; s=0 and cnt=DEBOUNCE_CYCLES-1 -> RELEASED, btn_level<=0, btn_release pulse, cnt=0; else cnt+1.
- A release bounce that returns to PRESSED never emits a second btn_press; the long-press timer restarts from that point.
- Channels fully independent; simultaneous events on several channels produce simultaneous pulses.
- Pulses are registered outputs, high for exactly one cycle, cleared the following cycle unconditionally.

## Timing
- Reset values: btn_level=0, btn_press=0, btn_release=0, btn_long=0, sync flops=0 (released), all FSMs RELEASED, counters 0.
- Reset asserted mid-operation: next edge forces reset values regardless of state; a button still held after reset deasserts is re-debounced and yields a fresh btn_press.
- Latency: if btn_in changes and stays stable, the new value is sampled at edge E; sync2 shows it at E+1. btn_level changes, and the btn_press/btn_release pulse asserts, at edge E+1+DEBOUNCE_CYCLES.
- Rejection: any pulse or glitch shorter than DEBOUNCE_CYCLES sampled cycles produces no output change.
- btn_long asserts exactly LONG_CYCLES edges after the btn_press edge, provided s stays 1 throughout.
- btn_press and btn_release are never both high on one channel in the same cycle; btn_long never coincides with btn_press.

## Test plan
Bench uses DEBOUNCE_CYCLES=8, LONG_CYCLES=40, CHANNELS=5, ACTIVE_LOW=0 unless stated.
- Clean press: ch0 high for 20 cycles then low -> btn_level[0] rises 9 edges after first sampling edge; one btn_press cycle; falls 9 edges after release with one btn_release; no btn_long.
- Glitch: ch1 high for 5 cycles -> btn_level, btn_press, btn_release all stay 0.
- Bounce: ch2 toggles 1,0,1,0 every 2 cycles then holds 1 -> exactly one btn_press, 9 edges after the final rising sample.
- Long press: ch3 held 60 cycles -> btn_press at t, single btn_long at t+40, one btn_release after release; holding 200 cycles still gives one btn_long.
- Independence and reset: ch0 and ch4 pressed same cycle -> simultaneous btn_press on bits 0 and 4; reset pulsed mid-press while ch4 held -> all outputs 0 next edge, then fresh btn_press[4] 9 edges after reset deasserts.
- Polarity: ACTIVE_LOW=1, btn_in idle all-ones, ch0 driven 0 for 20 cycles -> btn_level[0]=1 with one btn_press; idle-high inputs produce no events.
